// File: rtl/reg_counter_pkg.sv
// rtl/reg_counter_pkg.sv - shared constants, types and step function for the counter bank
package reg_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter supported; lanes zero-extend into this word for the step function.
    localparam int CNT_MAX_W = 64;

    typedef logic [CNT_MAX_W-1:0] cnt_word_t;

    typedef struct packed {
        cnt_word_t next_val;
        logic      term;
    } step_t;

    // One count step. max_val is the all-ones value of the caller's width, so the
    // +1/-1 below never crosses the caller's width and arithmetic stays modulo WIDTH.
    function automatic step_t cnt_step(input cnt_word_t val, input cnt_word_t max_val,
                                       input logic down, input logic sat);
        step_t res;
        res.next_val = val;
        res.term     = 1'b0;
        if (down == DIR_UP) begin
            if (val == max_val) begin
                res.term     = 1'b1;
                res.next_val = (sat == MODE_WRAP) ? '0 : max_val;
            end else begin
                res.next_val = val + 1'b1;
            end
        end
        if (down == DIR_DOWN) begin
            if (val == '0) begin
                res.term     = 1'b1;
                res.next_val = (sat == MODE_SAT) ? '0 : max_val;
            end else begin
                res.next_val = val - 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_counter_bank_if.sv
// rtl/reg_counter_bank_if.sv - load handshake interface for the counter bank
interface reg_counter_bank_if #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2
) ();

    logic             load_valid;
    logic [CH_W-1:0]  load_ch;
    logic [WIDTH-1:0] load_val;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_ch,
        output load_val,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_val,
        output load_ready
    );

endinterface

// File: rtl/reg_counter_lane.sv
// rtl/reg_counter_lane.sv - one counter channel: count, terminal pulse and sticky overflow
module reg_counter_lane
    import reg_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             down,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             term_pulse,
    output logic             ovf
);

    localparam cnt_word_t MAX_VAL = cnt_word_t'({WIDTH{1'b1}});

    step_t            step;
    logic [WIDTH-1:0] count_nxt;
    logic             term_nxt;
    logic             ovf_set;
    logic             ovf_nxt;

    // Upper bits of the shared step word are always zero for this lane.
    if (WIDTH < CNT_MAX_W) begin : g_hi
        logic [CNT_MAX_W-WIDTH-1:0] unused_hi;
        assign unused_hi = step.next_val[CNT_MAX_W-1:WIDTH];
    end

    // Next-state selection: clr beats load, load beats enable; set of ovf beats ovf_clr.
    always_comb begin
        step      = cnt_step(cnt_word_t'(count), MAX_VAL, down, sat);
        count_nxt = count;
        term_nxt  = 1'b0;
        ovf_set   = 1'b0;
        if (clr) begin
            count_nxt = INIT_VAL;
        end else if (load) begin
            count_nxt = load_val;
        end else if (en) begin
            count_nxt = step.next_val[WIDTH-1:0];
            term_nxt  = step.term;
            ovf_set   = step.term;
        end
        if (clr) begin
            ovf_nxt = 1'b0;
        end else if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf;
        end
    end

    // Lane state register with asynchronous reset to the init value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= INIT_VAL;
            term_pulse <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            count      <= count_nxt;
            term_pulse <= term_nxt;
            ovf        <= ovf_nxt;
        end
    end

endmodule

// File: rtl/reg_counter_bank.sv
// rtl/reg_counter_bank.sv - multi-channel up/down wrap/saturate counter bank with load port
module reg_counter_bank
    import reg_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS-1:0]       ch_down,
    input  logic [CHANNELS-1:0]       ch_sat,
    input  logic [CHANNELS-1:0]       ovf_clr,
    reg_counter_bank_if.slave         load_if,
    output logic [CHANNELS*WIDTH-1:0] count_val,
    output logic [CHANNELS-1:0]       is_zero,
    output logic [CHANNELS-1:0]       term_pulse,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic load_fire;

    // Loads are refused only while reset or clear is active; out-of-range channels are dropped.
    assign load_if.load_ready = ~rst & ~clr;
    assign load_fire          = load_if.load_valid & load_if.load_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic load_hit;

        assign load_hit = load_fire & (load_if.load_ch == CH_W'(i));

        reg_counter_lane #(
            .WIDTH    (WIDTH),
            .INIT_VAL (INIT_VAL)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .en         (ch_en[i]),
            .down       (ch_down[i]),
            .sat        (ch_sat[i]),
            .load       (load_hit),
            .load_val   (load_if.load_val),
            .ovf_clr    (ovf_clr[i]),
            .count      (count_val[i*WIDTH +: WIDTH]),
            .term_pulse (term_pulse[i]),
            .ovf        (ovf[i])
        );

        assign is_zero[i] = (count_val[i*WIDTH +: WIDTH] == '0);
    end

endmodule

// File: tb/tb_reg_counter_bank.sv
// tb/tb_reg_counter_bank.sv - directed table-driven bench for reg_counter_bank
module tb_reg_counter_bank;

    localparam int         WIDTH    = 8;
    localparam int         CHANNELS = 5;
    localparam int         CH_W     = 3;
    localparam logic [7:0] INIT     = 8'h05;
    localparam int         NVEC     = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [4:0]  ch_en;
    logic [4:0]  ch_down;
    logic [4:0]  ch_sat;
    logic [4:0]  ovf_clr;
    logic [39:0] count_val;
    logic [4:0]  is_zero;
    logic [4:0]  term_pulse;
    logic [4:0]  ovf;

    reg_counter_bank_if #(.WIDTH(WIDTH), .CH_W(CH_W)) lif ();

    reg_counter_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .INIT_VAL (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ch_en      (ch_en),
        .ch_down    (ch_down),
        .ch_sat     (ch_sat),
        .ovf_clr    (ovf_clr),
        .load_if    (lif.slave),
        .count_val  (count_val),
        .is_zero    (is_zero),
        .term_pulse (term_pulse),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [4:0]  en;
        logic [4:0]  down;
        logic [4:0]  sat;
        logic        lv;
        logic [2:0]  lch;
        logic [7:0]  lval;
        logic [4:0]  oclr;
        logic        rdy;
        logic [39:0] cnt;
        logic [4:0]  term;
        logic [4:0]  ovfv;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] zero_of(input logic [39:0] c);
        logic [4:0] z;
        for (int i = 0; i < 5; i++) z[i] = (c[i*8 +: 8] == 8'h00);
        return z;
    endfunction

    function automatic vec_t mk(input logic c, input logic [4:0] en, input logic [4:0] dn,
                                input logic [4:0] st, input logic lv, input logic [2:0] lch,
                                input logic [7:0] lval, input logic [4:0] oc, input logic rdy,
                                input logic [39:0] cnt, input logic [4:0] tp, input logic [4:0] ov);
        vec_t v;
        v.clr = c;   v.en = en;   v.down = dn;  v.sat = st;
        v.lv = lv;   v.lch = lch; v.lval = lval; v.oclr = oc;
        v.rdy = rdy; v.cnt = cnt; v.term = tp;  v.ovfv = ov;
        return v;
    endfunction

    task automatic idle_inputs();
        clr = 1'b0; ch_en = '0; ch_down = '0; ch_sat = '0; ovf_clr = '0;
        lif.load_valid = 1'b0; lif.load_ch = '0; lif.load_val = '0;
    endtask

    initial begin
        // counts are {ch4, ch3, ch2, ch1, ch0}
        vecs[0]  = mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 3'd1, 8'h02, 5'b00000, 1, 40'h0505050205, 5'b00000, 5'b00000);
        vecs[1]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505050105, 5'b00000, 5'b00000);
        vecs[2]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505050005, 5'b00000, 5'b00000);
        vecs[3]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505050005, 5'b00010, 5'b00010);
        vecs[4]  = mk(0, 5'b00010, 5'b00010, 5'b00010, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505050005, 5'b00010, 5'b00010);
        vecs[5]  = mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00010, 1, 40'h0505050005, 5'b00000, 5'b00000);
        vecs[6]  = mk(0, 5'b00100, 5'b00000, 5'b00000, 1, 3'd2, 8'h7F, 5'b00000, 1, 40'h05057F0005, 5'b00000, 5'b00000);
        vecs[7]  = mk(0, 5'b00100, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505800005, 5'b00000, 5'b00000);
        vecs[8]  = mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 3'd3, 8'hFE, 5'b00000, 1, 40'h05FE800005, 5'b00000, 5'b00000);
        vecs[9]  = mk(0, 5'b01000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h05FF800005, 5'b00000, 5'b00000);
        vecs[10] = mk(0, 5'b01000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b01000, 1, 40'h0500800005, 5'b01000, 5'b01000);
        vecs[11] = mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b01000, 1, 40'h0500800005, 5'b00000, 5'b00000);
        vecs[12] = mk(0, 5'b01000, 5'b01000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h05FF800005, 5'b01000, 5'b01000);
        vecs[13] = mk(0, 5'b11000, 5'b01000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h06FE800005, 5'b00000, 5'b01000);
        vecs[14] = mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 3'd5, 8'hAA, 5'b00000, 1, 40'h06FE800005, 5'b00000, 5'b01000);
        vecs[15] = mk(0, 5'b00100, 5'b00000, 5'b00000, 1, 3'd7, 8'h33, 5'b00000, 1, 40'h06FE810005, 5'b00000, 5'b01000);
        vecs[16] = mk(1, 5'b11111, 5'b00000, 5'b00000, 1, 3'd1, 8'h99, 5'b00000, 0, 40'h0505050505, 5'b00000, 5'b00000);
        vecs[17] = mk(0, 5'b10000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0605050505, 5'b00000, 5'b00000);
        vecs[18] = mk(0, 5'b10000, 5'b10000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0505050505, 5'b00000, 5'b00000);
        vecs[19] = mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 3'd4, 8'hFF, 5'b00000, 1, 40'hFF05050505, 5'b00000, 5'b00000);
        vecs[20] = mk(0, 5'b10000, 5'b00000, 5'b10000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'hFF05050505, 5'b10000, 5'b10000);
        vecs[21] = mk(0, 5'b10000, 5'b00000, 5'b10000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'hFF05050505, 5'b10000, 5'b10000);
        vecs[22] = mk(0, 5'b10000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0005050505, 5'b10000, 5'b10000);
        vecs[23] = mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd0, 8'h00, 5'b00000, 1, 40'h0005050505, 5'b00000, 5'b10000);

        // Reset state
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_count", 64'(count_val), 64'(40'h0505050505));
        check("rst_term", 64'(term_pulse), 64'(5'b00000));
        check("rst_ovf", 64'(ovf), 64'(5'b00000));
        check("rst_is_zero", 64'(is_zero), 64'(5'b00000));
        check("rst_ready", 64'(lif.load_ready), 64'(1'b0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(lif.load_ready), 64'(1'b1));

        // Directed vector table
        for (int v = 0; v < NVEC; v++) begin
            clr = vecs[v].clr; ch_en = vecs[v].en; ch_down = vecs[v].down; ch_sat = vecs[v].sat;
            ovf_clr = vecs[v].oclr;
            lif.load_valid = vecs[v].lv; lif.load_ch = vecs[v].lch; lif.load_val = vecs[v].lval;
            #1;
            check($sformatf("vec%0d_ready", v), 64'(lif.load_ready), 64'(vecs[v].rdy));
            tick();
            check($sformatf("vec%0d_count", v), 64'(count_val), 64'(vecs[v].cnt));
            check($sformatf("vec%0d_term", v), 64'(term_pulse), 64'(vecs[v].term));
            check($sformatf("vec%0d_ovf", v), 64'(ovf), 64'(vecs[v].ovfv));
            check($sformatf("vec%0d_is_zero", v), 64'(is_zero), 64'(zero_of(vecs[v].cnt)));
        end
        idle_inputs();

        // Full 256-step up/wrap sweep on ch0
        lif.load_valid = 1'b1; lif.load_ch = 3'd0; lif.load_val = 8'h00;
        tick();
        lif.load_valid = 1'b0;
        check("sweep_start", 64'(count_val[7:0]), 64'(8'h00));
        check("sweep_start_zero", 64'(is_zero[0]), 64'(1'b1));
        ch_en = 5'b00001;
        for (int k = 1; k <= 256; k++) begin
            tick();
            check($sformatf("sweep%0d_count", k), 64'(count_val[7:0]), 64'(k % 256));
            check($sformatf("sweep%0d_term", k), 64'(term_pulse[0]), 64'(k == 256));
            check($sformatf("sweep%0d_zero", k), 64'(is_zero[0]), 64'(k == 256));
            check($sformatf("sweep%0d_ovf", k), 64'(ovf[0]), 64'(k == 256));
        end
        tick();
        check("sweep_term_one_cycle", 64'(term_pulse[0]), 64'(1'b0));
        check("sweep_after_count", 64'(count_val[7:0]), 64'(8'h01));
        check("sweep_ovf_sticky", 64'(ovf[0]), 64'(1'b1));

        // Asynchronous reset in the middle of counting
        ch_en = '0;
        lif.load_valid = 1'b1; lif.load_ch = 3'd0; lif.load_val = 8'h3F;
        tick();
        lif.load_valid = 1'b0;
        ch_en = 5'b00001;
        tick();
        check("pre_rst_count", 64'(count_val[7:0]), 64'(8'h40));
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count_val), 64'(40'h0505050505));
        check("async_rst_ovf", 64'(ovf), 64'(5'b00000));
        check("async_rst_term", 64'(term_pulse), 64'(5'b00000));
        check("async_rst_ready", 64'(lif.load_ready), 64'(1'b0));
        tick();
        check("held_rst_count", 64'(count_val), 64'(40'h0505050505));
        ch_en = '0;
        rst = 1'b0;
        tick();
        check("post_rst_hold", 64'(count_val), 64'(40'h0505050505));
        ch_en = 5'b00001;
        tick();
        check("post_rst_first_count", 64'(count_val), 64'(40'h0505050506));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_counter_bank.md
Name: reg_counter_bank

Overview:
- Parametrised, multi-channel successor to the single 8-bit free-running counter.
- Provides CHANNELS independent counters of WIDTH bits, each with:
  - a deterministic reset/init value
  - per-channel enable, direction (up/down) and wrap-or-saturate mode
  - a handshaked load port
  - zero flag, registered terminal pulse and sticky overflow flag
- Sits beside event sources (perf/debug counters, timeout generators) as a reusable counting primitive.

Parameters:
- WIDTH, 8, bit width of each counter (>=2).
- CHANNELS, 4, number of independent counters (>=1).
- INIT_VAL, 0, value every counter takes on reset and on clr; truncated to WIDTH.
- CH_W, $clog2(CHANNELS) (min 1), derived, width of load_ch; not overridable.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of all channels to INIT_VAL, and clears all ovf.
- ch_en  input  CHANNELS  per-channel count enable.
- ch_down  input  CHANNELS  1 = decrement, 0 = increment.
- ch_sat  input  CHANNELS  1 = saturate at bound, 0 = wrap.
- load_valid  input  1  load request.
- load_ch  input  CH_W  target channel of load.
- load_val  input  WIDTH  value to load.
- load_ready  output  1  load accepted this cycle when valid&ready.
- ovf_clr  input  CHANNELS  per-channel clear of sticky ovf.
- count_val  output  CHANNELS*WIDTH  counters, channel i at bits [i*WIDTH +: WIDTH].
- is_zero  output  CHANNELS  combinational (count_val[i] == 0).
- term_pulse  output  CHANNELS  registered 1-cycle pulse on wrap or saturation hit.
- ovf  output  CHANNELS  sticky: set on wrap or saturation attempt.

Behaviour:
- Reset (rst=1, async):
  - count = INIT_VAL, term_pulse = 0, ovf = 0 on all channels.
  - is_zero reflects (INIT_VAL==0).
  - load_ready = 0 while rst is high.
- load_ready = ~rst & ~clr. It is combinational, with no dependency on load_valid.
- Per-channel next-state priority, highest first:
  - clr: count = INIT_VAL, term_pulse = 0, ovf = 0.
  - load (load_valid & load_ready & load_ch==i): count = load_val, term_pulse = 0. ovf unchanged. Load overrides ch_en the same cycle.
  - ch_en[i]: step by 1 in the selected direction.
  - else: hold, term_pulse = 0.
- Step rules, up direction, at max (all ones):
  - wrap mode: count becomes 0, term_pulse=1, ovf=1.
  - sat mode: count stays max, term_pulse=1 (every enabled cycle at max), ovf=1.
- Step rules, down direction, at 0:
  - wrap mode: count becomes max, term_pulse=1, ovf=1.
  - sat mode: count stays 0, term_pulse=1, ovf=1.
- Otherwise count ±1 and term_pulse=0.
- Arithmetic is WIDTH-bit modulo; no carry leaks across channels.
- ovf_clr[i] clears ovf[i] unless the same cycle sets it: set wins over ovf_clr. clr wins over both.
- load_ch >= CHANNELS: the load is accepted (ready high) and discarded; no channel changes.
- Latency:
  - count_val and term_pulse update 1 cycle after the enabling edge.
  - is_zero has zero latency from count.
- Mode/direction inputs are sampled every cycle. Changing them mid-count affects only the next step.
- Reset asserted mid-operation aborts everything. First count after deassertion happens on the first posedge with ch_en=1.

Decomposition:
- Package reg_counter_pkg:
  - direction constants DIR_UP=0, DIR_DOWN=1
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - function cnt_step(val, down, sat) returning {next, term}
- Sub-module reg_counter_lane (one channel: count, term_pulse, ovf), instantiated CHANNELS times via generate.
- Top level handles load decode, load_ready and output packing.

Test Plan:
- WIDTH=8, INIT_VAL=0: assert rst, release, ch_en[0]=1 for 256 cycles, up/wrap -> count 0,1,..,255,0; term_pulse[0] high exactly 1 cycle at 255->0; ovf[0]=1; is_zero[0] high at 0.
- INIT_VAL=8'h05, rst pulse mid-count (count=0x40) -> all counters 0x05 immediately (async); load_ready low during rst; term_pulse/ovf 0.
- Ch1 down/sat from load 0x02, ch_en=1 for 4 cycles -> 1,0,0,0; term_pulse[1] high on the 2 cycles at 0 with enable; ovf[1]=1; then ovf_clr[1] -> ovf[1]=0.
- Same cycle: load_valid=1, load_ch=2, load_val=0x7F, ch_en[2]=1 -> count[2]=0x7F (load wins); next enabled cycle -> 0x80.
- clr=1 with load_valid=1 -> load_ready=0, all counts INIT_VAL, all ovf=0; load_ch=CHANNELS (when CHANNELS<2**CH_W) -> accepted and no channel changes.
- ovf_clr[3] asserted in the cycle ch3 wraps -> ovf[3] stays 1.
